// File: rtl/stc_pe_stream.sv
// Streaming sparse-tensor PE: accumulates one output row D = C + sum_k a_k * B_k.
// Stage 1 registers the lane products, stage 2 adds them into a wide accumulator
// with optional clamping. C, A and D move over valid/ready handshakes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a C row; c_ready=1
// S_ACC   | accepting A elements; a_ready=1
// S_FLUSH | last product in stage 1, applied on the next edge
// S_DONE  | D row valid and held until d_ready
module stc_pe_stream #(
    parameter int N       = 32,
    parameter int DW_DATA = 8,
    parameter int DW_ACC  = 24,
    parameter bit SIGNED  = 1'b1,
    parameter bit SAT_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c_valid,
    output logic                   c_ready,
    input  logic [N*DW_ACC-1:0]    C_row,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [DW_DATA-1:0]     A_element,
    input  logic [N*DW_DATA-1:0]   B_row,
    input  logic                   a_last,
    output logic                   d_valid,
    input  logic                   d_ready,
    output logic [N*DW_ACC-1:0]    D_row,
    output logic                   sat
);

    localparam int PW = 2 * DW_DATA;
    localparam int XW = DW_ACC + 1 - PW;
    localparam logic [DW_ACC-1:0] ACC_MAX = SIGNED ? {1'b0, {(DW_ACC-1){1'b1}}} : {DW_ACC{1'b1}};
    localparam logic [DW_ACC-1:0] ACC_MIN = SIGNED ? {1'b1, {(DW_ACC-1){1'b0}}} : {DW_ACC{1'b0}};

    if (DW_ACC < 2 * DW_DATA) begin : g_bad_width
        $error("stc_pe_stream: DW_ACC must be at least 2*DW_DATA");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_DONE} state_t;

    state_t            state;
    logic              s1_v;
    logic [PW-1:0]     p       [N];
    logic [DW_ACC-1:0] acc     [N];
    logic [PW-1:0]     a_x;
    logic [PW-1:0]     b_x     [N];
    logic [PW-1:0]     prod    [N];
    logic [DW_ACC:0]   sum     [N];
    logic [DW_ACC-1:0] acc_nxt [N];
    logic [N-1:0]      clamp;
    logic              ovf;

    // Operands widened to the product width so the low PW bits are the exact product.
    always_comb begin
        a_x = SIGNED ? {{DW_DATA{A_element[DW_DATA-1]}}, A_element} : {{DW_DATA{1'b0}}, A_element};
        b_x  = '{default: '0};
        prod = '{default: '0};
        for (int j = 0; j < N; j++) begin
            b_x[j]  = SIGNED ? {{DW_DATA{B_row[j*DW_DATA+DW_DATA-1]}}, B_row[j*DW_DATA +: DW_DATA]}
                             : {{DW_DATA{1'b0}}, B_row[j*DW_DATA +: DW_DATA]};
            prod[j] = a_x * b_x[j];
        end
    end

    // One-bit-wider sum per lane, then clamp or wrap back into the accumulator range.
    always_comb begin
        sum     = '{default: '0};
        acc_nxt = '{default: '0};
        clamp   = '0;
        ovf     = 1'b0;
        for (int j = 0; j < N; j++) begin
            sum[j] = (SIGNED ? {acc[j][DW_ACC-1], acc[j]} : {1'b0, acc[j]})
                   + (SIGNED ? {{XW{p[j][PW-1]}}, p[j]} : {{XW{1'b0}}, p[j]});
            ovf = SIGNED ? (sum[j][DW_ACC] ^ sum[j][DW_ACC-1]) : sum[j][DW_ACC];
            if (SAT_EN && ovf) begin
                clamp[j]   = 1'b1;
                acc_nxt[j] = (SIGNED && sum[j][DW_ACC]) ? ACC_MIN : ACC_MAX;
            end else begin
                acc_nxt[j] = sum[j][DW_ACC-1:0];
            end
        end
    end

    // Control FSM, product stage and accumulator stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            s1_v  <= 1'b0;
            sat   <= 1'b0;
            for (int j = 0; j < N; j++) begin
                p[j]   <= '0;
                acc[j] <= '0;
            end
        end else begin
            if ((state == S_ACC || state == S_FLUSH) && s1_v) begin
                for (int j = 0; j < N; j++) acc[j] <= acc_nxt[j];
                sat <= sat | (|clamp);
            end
            case (state)
                S_IDLE: begin
                    s1_v <= 1'b0;
                    if (c_valid) begin
                        for (int j = 0; j < N; j++) acc[j] <= C_row[j*DW_ACC +: DW_ACC];
                        sat   <= 1'b0;
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    s1_v <= a_valid;
                    if (a_valid) begin
                        for (int j = 0; j < N; j++) p[j] <= prod[j];
                        if (a_last) state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    s1_v  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    s1_v <= 1'b0;
                    if (d_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    always_comb begin
        c_ready = (state == S_IDLE);
        a_ready = (state == S_ACC);
        d_valid = (state == S_DONE);
    end

    // D row is the accumulator itself.
    always_comb begin
        D_row = '0;
        for (int j = 0; j < N; j++) D_row[j*DW_ACC +: DW_ACC] = acc[j];
    end

endmodule

// File: tb/tb_stc_pe_stream.sv
// Directed and table-driven bench for stc_pe_stream (N=4, 8-bit data, 24-bit acc).
// Two instances share stimulus: one saturating, one wrapping.
module tb_stc_pe_stream;

    localparam int N  = 4;
    localparam int DD = 8;
    localparam int DA = 24;

    typedef struct {
        logic [N*DA-1:0]          c;
        int                       n;
        logic [7:0][DD-1:0]       a;
        logic [7:0][N*DD-1:0]     b;
        logic [N*DA-1:0]          d;
        logic                     s;
        logic [N*DA-1:0]          dw;
        logic                     sw;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              c_valid = 1'b0;
    logic [N*DA-1:0]   C_row = '0;
    logic              a_valid = 1'b0;
    logic [DD-1:0]     A_element = '0;
    logic [N*DD-1:0]   B_row = '0;
    logic              a_last = 1'b0;
    logic              d_ready = 1'b0;
    logic              c_ready, a_ready, d_valid, sat;
    logic [N*DA-1:0]   D_row;
    logic              c_ready_w, a_ready_w, d_valid_w, sat_w;
    logic [N*DA-1:0]   D_row_w;

    int checks = 0;
    int errors = 0;

    stc_pe_stream #(.N(N), .DW_DATA(DD), .DW_ACC(DA), .SIGNED(1'b1), .SAT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .c_valid(c_valid), .c_ready(c_ready), .C_row(C_row),
        .a_valid(a_valid), .a_ready(a_ready), .A_element(A_element), .B_row(B_row),
        .a_last(a_last), .d_valid(d_valid), .d_ready(d_ready), .D_row(D_row), .sat(sat));

    stc_pe_stream #(.N(N), .DW_DATA(DD), .DW_ACC(DA), .SIGNED(1'b1), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .reset(reset), .c_valid(c_valid), .c_ready(c_ready_w), .C_row(C_row),
        .a_valid(a_valid), .a_ready(a_ready_w), .A_element(A_element), .B_row(B_row),
        .a_last(a_last), .d_valid(d_valid_w), .d_ready(d_ready), .D_row(D_row_w), .sat(sat_w));

    always #5 clk = ~clk;

    function automatic logic [N*DA-1:0] pk4(input int l0, input int l1, input int l2, input int l3);
        int v[4];
        logic [N*DA-1:0] r;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DA +: DA] = v[j][DA-1:0];
        return r;
    endfunction

    function automatic logic [N*DD-1:0] pb4(input int l0, input int l1, input int l2, input int l3);
        int v[4];
        logic [N*DD-1:0] r;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DD +: DD] = v[j][DD-1:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [N*DA-1:0] act, input logic [N*DA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // a_ready must never coexist with the IDLE or DONE indications.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((a_ready && (c_ready || d_valid)) || (a_ready_w && (c_ready_w || d_valid_w))) begin
                errors++;
                $display("FAIL a_ready_exclusive actual=%b%b%b required=a_ready alone", a_ready, c_ready, d_valid);
            end
        end
    end

    // Load C, stream the elements, check the D timing, hold DONE for 'stall' cycles, then drain.
    task automatic run_vec(input vec_t v, input int stall, input bit bubbles, input string nm);
        @(negedge clk);
        chk({nm, "_c_ready"}, c_ready, 1);
        c_valid = 1'b1;
        C_row   = v.c;
        @(negedge clk);
        c_valid = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk);
            a_valid   = 1'b1;
            A_element = v.a[i];
            B_row     = v.b[i];
            a_last    = (i == v.n - 1);
            chk({nm, "_a_ready"}, a_ready, 1);
            @(negedge clk);
            a_valid = 1'b0;
            a_last  = 1'b0;
        end
        chk({nm, "_flush_d_valid"}, d_valid, 0);
        chk({nm, "_flush_a_ready"}, a_ready, 0);
        @(negedge clk);
        chk({nm, "_d_valid"}, d_valid, 1);
        chk({nm, "_d_row"}, D_row, v.d);
        chk({nm, "_sat"}, sat, v.s);
        chk({nm, "_d_row_wrap"}, D_row_w, v.dw);
        chk({nm, "_sat_wrap"}, sat_w, v.sw);
        for (int s = 0; s < stall; s++) begin
            c_valid   = 1'b1;
            C_row     = pk4(77, 77, 77, 77);
            a_valid   = 1'b1;
            a_last    = 1'b1;
            A_element = 8'd9;
            @(negedge clk);
            chk({nm, "_hold_d_valid"}, d_valid, 1);
            chk({nm, "_hold_d_row"}, D_row, v.d);
            chk({nm, "_hold_a_ready"}, a_ready, 0);
            chk({nm, "_hold_c_ready"}, c_ready, 0);
        end
        c_valid = 1'b0;
        a_valid = 1'b0;
        a_last  = 1'b0;
        d_ready = 1'b1;
        @(negedge clk);
        d_ready = 1'b0;
        chk({nm, "_idle_c_ready"}, c_ready, 1);
        chk({nm, "_idle_d_valid"}, d_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t r;
        int   cl[4];
        longint ss[4];
        longint ww[4];
        bit   sf;
        byte  av, bv;
        int   prod;

        // 1: single element, C={1,2,3,4}, A=2, B=1s.
        vecs[0].c = pk4(1, 2, 3, 4); vecs[0].n = 1;
        vecs[0].a[0] = 8'd2; vecs[0].b[0] = pb4(1, 1, 1, 1);
        vecs[0].d = pk4(3, 4, 5, 6); vecs[0].s = 1'b0;
        vecs[0].dw = pk4(3, 4, 5, 6); vecs[0].sw = 1'b0;
        // 2: three back-to-back elements with negatives.
        vecs[1].c = '0; vecs[1].n = 3;
        vecs[1].a[0] = 8'd1;  vecs[1].b[0] = pb4(1, 2, 3, 4);
        vecs[1].a[1] = 8'hFF; vecs[1].b[1] = pb4(4, 3, 2, 1);
        vecs[1].a[2] = 8'd3;  vecs[1].b[2] = pb4(0, 0, 0, -5);
        vecs[1].d = pk4(-3, -1, 1, -12); vecs[1].s = 1'b0;
        vecs[1].dw = pk4(-3, -1, 1, -12); vecs[1].sw = 1'b0;
        // 3: positive overflow: 8388600 + 16129 = 8404729 -> clamp 8388607 / wrap -8372487.
        vecs[2].c = pk4(8388600, 0, 0, 0); vecs[2].n = 1;
        vecs[2].a[0] = 8'd127; vecs[2].b[0] = pb4(127, 0, 0, 0);
        vecs[2].d = pk4(8388607, 0, 0, 0); vecs[2].s = 1'b1;
        vecs[2].dw = pk4(-8372487, 0, 0, 0); vecs[2].sw = 1'b0;
        // Empty row: A=0 leaves C unchanged.
        vecs[3].c = pk4(5, -6, 7, -8); vecs[3].n = 1;
        vecs[3].a[0] = 8'd0; vecs[3].b[0] = pb4(9, 9, 9, 9);
        vecs[3].d = pk4(5, -6, 7, -8); vecs[3].s = 1'b0;
        vecs[3].dw = pk4(5, -6, 7, -8); vecs[3].sw = 1'b0;
        // Negative overflow: -8388600 - 16256 = -8404856 -> clamp -8388608 / wrap 8372360.
        vecs[4].c = pk4(-8388600, 10, 0, 0); vecs[4].n = 1;
        vecs[4].a[0] = 8'h80; vecs[4].b[0] = pb4(127, 0, 0, 0);
        vecs[4].d = pk4(-8388608, 10, 0, 0); vecs[4].s = 1'b1;
        vecs[4].dw = pk4(8372360, 10, 0, 0); vecs[4].sw = 1'b0;

        #1 reset = 1'b1;
        #2;
        chk("rst_c_ready", c_ready, 1);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_d_row", D_row, '0);
        chk("rst_sat", sat, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], (i == 1) ? 5 : 0, 1'b0, $sformatf("vec%0d", i));

        // Reset in the middle of a row after two elements.
        @(negedge clk);
        c_valid = 1'b1;
        C_row   = pk4(100, 200, 300, 400);
        @(negedge clk);
        c_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_valid   = 1'b1;
            A_element = 8'd3;
            B_row     = pb4(1, 1, 1, 1);
            @(negedge clk);
        end
        a_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_c_ready", c_ready, 1);
        chk("midrst_a_ready", a_ready, 0);
        chk("midrst_d_valid", d_valid, 0);
        chk("midrst_d_row", D_row, '0);
        chk("midrst_sat", sat, 0);
        @(negedge clk);
        chk("midrst_hold_d_row", D_row, '0);
        reset = 1'b0;
        run_vec(vecs[0], 0, 1'b0, "after_rst");

        // Random rows with bubbles against a per-step clamping model.
        for (int t = 0; t < 3; t++) begin
            sf = 1'b0;
            for (int j = 0; j < N; j++) begin
                cl[j] = (t == 0) ? int'($urandom_range(0, 2000)) - 1000
                                 : int'($urandom_range(0, 16777215)) - 8388608;
                ss[j] = cl[j];
                ww[j] = cl[j];
            end
            r.c = pk4(cl[0], cl[1], cl[2], cl[3]);
            r.n = 8;
            for (int i = 0; i < 8; i++) begin
                av = byte'($urandom);
                r.a[i] = av;
                for (int j = 0; j < N; j++) begin
                    bv = byte'($urandom);
                    r.b[i][j*DD +: DD] = bv;
                    prod = int'(av) * int'(bv);
                    ss[j] += prod;
                    ww[j] += prod;
                    if (ss[j] > 64'sd8388607) begin ss[j] = 8388607; sf = 1'b1; end
                    if (ss[j] < -64'sd8388608) begin ss[j] = -8388608; sf = 1'b1; end
                end
            end
            r.d  = pk4(int'(ss[0]), int'(ss[1]), int'(ss[2]), int'(ss[3]));
            r.s  = sf;
            r.dw = pk4(int'(ww[0]), int'(ww[1]), int'(ww[2]), int'(ww[3]));
            r.sw = 1'b0;
            run_vec(r, 1, 1'b1, $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
